// File: rtl/debug_pkg.sv
// Debug link definitions shared by the host and the
// target-side debug unit: commands, states, kinds.
package debug_pkg;

  typedef enum logic [7:0] {
    CMD_WRITE_IM     = 8'd1,
    CMD_START        = 8'd2,
    CMD_STEP_BY_STEP = 8'd3,
    CMD_SEND_BR      = 8'd4,
    CMD_SEND_MEM     = 8'd5,
    CMD_SEND_PC      = 8'd6,
    CMD_STEP         = 8'd7,
    CMD_CONTINUE     = 8'd8
  } cmd_e;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd1,
    ST_TX_CMD    = 4'd2,
    ST_WAIT_CMD  = 4'd3,
    ST_TX_PROG   = 4'd4,
    ST_WAIT_PROG = 4'd5,
    ST_RX_PC     = 4'd6,
    ST_RX_MEM    = 4'd7,
    ST_RX_BR     = 4'd8
  } state_e;

  typedef enum logic [1:0] {
    KIND_PC  = 2'd0,
    KIND_MEM = 2'd1,
    KIND_BR  = 2'd2
  } kind_e;

  localparam logic [6:0] PC_LAST   = 7'd3;
  localparam logic [6:0] BLK_LAST  = 7'd127;
  localparam logic [7:0] PROG_LAST = 8'd255;

  function automatic logic cmd_legal(
    input logic [7:0] c
  );
    return (c >= CMD_WRITE_IM) &&
           (c <= CMD_CONTINUE);
  endfunction

endpackage

// File: rtl/debug_word_assembler.sv
// Shifts received bytes MSB first into a word and
// strobes the word once i_count bytes have arrived.
module debug_word_assembler
  import debug_pkg::*;
#(
  parameter int NB_DATA = 8,
  parameter int NB_WORD = 32
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_clear,
  input  logic               i_valid,
  input  logic [NB_DATA-1:0] i_byte,
  input  logic [2:0]         i_count,
  output logic [NB_WORD-1:0] o_word,
  output logic               o_valid
);

  logic [NB_WORD-1:0] acc;
  logic [NB_WORD-1:0] acc_nxt;
  logic [2:0]         cnt;
  logic               last;

  assign acc_nxt = {acc[NB_WORD-NB_DATA-1:0], i_byte};
  assign last    = (cnt == i_count - 3'd1);

  // acc is zero at each word start, so a 1-byte word
  // comes out zero-extended
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      acc     <= '0;
      cnt     <= '0;
      o_word  <= '0;
      o_valid <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      if (i_clear) begin
        acc <= '0;
        cnt <= '0;
      end else if (i_valid) begin
        if (last) begin
          acc     <= '0;
          cnt     <= '0;
          o_word  <= acc_nxt;
          o_valid <= 1'b1;
        end else begin
          acc <= acc_nxt;
          cnt <= cnt + 3'd1;
        end
      end
    end
  end

endmodule

// File: rtl/debug_host.sv
// Host side of the UART debug link: sends commands and
// program bytes, collects PC/MEM/BR responses.
module debug_host
  import debug_pkg::*;
#(
  parameter int NB_DATA        = 8,
  parameter int NB_WORD        = 32,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_cmd_valid,
  input  logic [7:0]         i_cmd,
  output logic               o_cmd_ready,
  input  logic               i_prog_valid,
  input  logic [NB_DATA-1:0] i_prog_data,
  output logic               o_prog_ready,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  input  logic               i_tx_done,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done,
  output logic [NB_WORD-1:0] o_resp_word,
  output logic               o_resp_valid,
  output logic [1:0]         o_resp_kind,
  output logic [6:0]         o_resp_index,
  output logic               o_done,
  output logic               o_error,
  output logic [3:0]         o_state
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST =
    TW'(TIMEOUT_CYCLES - 1);

  state_e        state;
  logic [7:0]    cmd_q;
  logic [7:0]    prog_cnt;
  logic [6:0]    byte_cnt;
  logic [6:0]    word_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          rx_state;
  logic          timed;
  logic          rx_hit;
  logic          word_end;
  logic          last_byte;
  logic          tmo_hit;
  logic [2:0]    asm_count;
  kind_e         rx_kind;

  assign rx_state = state inside
    {ST_RX_PC, ST_RX_MEM, ST_RX_BR};
  assign timed = rx_state || (state inside
    {ST_WAIT_CMD, ST_WAIT_PROG});
  assign rx_hit = rx_state && i_rx_done;

  assign word_end  = (state == ST_RX_MEM) ||
                     (byte_cnt[1:0] == 2'd3);
  assign last_byte = (state == ST_RX_PC) ?
                     (byte_cnt == PC_LAST) :
                     (byte_cnt == BLK_LAST);

  // a byte arriving on the terminal count wins
  assign tmo_hit = timed && !i_rx_done &&
                   !i_tx_done &&
                   (tmo_cnt == TMO_LAST);

  assign o_cmd_ready  = (state == ST_IDLE);
  assign o_prog_ready = (state == ST_TX_PROG) &&
                        i_prog_valid;
  assign o_state      = state;

  always_comb begin
    rx_kind   = KIND_PC;
    asm_count = 3'd4;
    unique case (1'b1)
      state == ST_RX_MEM: begin
        rx_kind   = KIND_MEM;
        asm_count = 3'd1;
      end
      state == ST_RX_BR: rx_kind = KIND_BR;
      default: ;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      tmo_cnt <= '0;
    end else if (!timed || i_rx_done || i_tx_done ||
                 tmo_cnt == TMO_LAST) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state        <= ST_IDLE;
      cmd_q        <= '0;
      prog_cnt     <= '0;
      byte_cnt     <= '0;
      word_cnt     <= '0;
      o_tx_data    <= '0;
      o_tx_start   <= 1'b0;
      o_resp_kind  <= '0;
      o_resp_index <= '0;
      o_done       <= 1'b0;
      o_error      <= 1'b0;
    end else begin
      o_tx_start <= 1'b0;
      o_done     <= 1'b0;
      o_error    <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (i_cmd_valid) begin
            if (cmd_legal(i_cmd)) begin
              cmd_q    <= i_cmd;
              prog_cnt <= '0;
              state    <= ST_TX_CMD;
            end else begin
              o_error <= 1'b1;
            end
          end
        end
        ST_TX_CMD: begin
          o_tx_data  <= NB_DATA'(cmd_q);
          o_tx_start <= 1'b1;
          state      <= ST_WAIT_CMD;
        end
        ST_WAIT_CMD: begin
          if (tmo_hit) begin
            o_error <= 1'b1;
            state   <= ST_IDLE;
          end else if (i_tx_done) begin
            byte_cnt <= '0;
            word_cnt <= '0;
            unique case (cmd_q)
              CMD_WRITE_IM: state <= ST_TX_PROG;
              CMD_SEND_PC,
              CMD_STEP:     state <= ST_RX_PC;
              CMD_SEND_MEM: state <= ST_RX_MEM;
              CMD_SEND_BR:  state <= ST_RX_BR;
              default: begin
                o_done <= 1'b1;
                state  <= ST_IDLE;
              end
            endcase
          end
        end
        ST_TX_PROG: begin
          if (i_prog_valid) begin
            o_tx_data  <= i_prog_data;
            o_tx_start <= 1'b1;
            state      <= ST_WAIT_PROG;
          end
        end
        ST_WAIT_PROG: begin
          if (tmo_hit) begin
            o_error <= 1'b1;
            state   <= ST_IDLE;
          end else if (i_tx_done) begin
            prog_cnt <= prog_cnt + 8'd1;
            if (prog_cnt == PROG_LAST) begin
              o_done <= 1'b1;
              state  <= ST_IDLE;
            end else begin
              state <= ST_TX_PROG;
            end
          end
        end
        ST_RX_PC, ST_RX_MEM, ST_RX_BR: begin
          if (tmo_hit) begin
            o_error <= 1'b1;
            state   <= ST_IDLE;
          end else if (i_rx_done) begin
            byte_cnt <= byte_cnt + 7'd1;
            if (word_end) begin
              o_resp_kind  <= rx_kind;
              o_resp_index <= word_cnt;
              word_cnt     <= word_cnt + 7'd1;
            end
            if (last_byte) begin
              byte_cnt <= '0;
              word_cnt <= '0;
              unique case (1'b1)
                state == ST_RX_PC &&
                cmd_q == CMD_STEP:
                  state <= ST_RX_MEM;
                state == ST_RX_MEM &&
                cmd_q == CMD_STEP:
                  state <= ST_RX_BR;
                default: begin
                  o_done <= 1'b1;
                  state  <= ST_IDLE;
                end
              endcase
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  debug_word_assembler #(
    .NB_DATA (NB_DATA),
    .NB_WORD (NB_WORD)
  ) u_asm (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_clear (!rx_state),
    .i_valid (rx_hit),
    .i_byte  (i_rx_data),
    .i_count (asm_count),
    .o_word  (o_resp_word),
    .o_valid (o_resp_valid)
  );

endmodule

// File: tb/tb_debug_host.sv
// Randomized bench for debug_host against a
// transaction-level model of the response stream.
module tb_debug_host;
  import debug_pkg::*;

  localparam int TMO = 300;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [7:0]  cmd = '0;
  logic        cmd_ready;
  logic        prog_valid = 1'b0;
  logic [7:0]  prog_data = '0;
  logic        prog_ready;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_done = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_done = 1'b0;
  logic [31:0] resp_word;
  logic        resp_valid;
  logic [1:0]  resp_kind;
  logic [6:0]  resp_index;
  logic        done;
  logic        error;
  logic [3:0]  st;

  always #5 clk = ~clk;

  debug_host #(.TIMEOUT_CYCLES(TMO)) dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_cmd_valid  (cmd_valid),
    .i_cmd        (cmd),
    .o_cmd_ready  (cmd_ready),
    .i_prog_valid (prog_valid),
    .i_prog_data  (prog_data),
    .o_prog_ready (prog_ready),
    .o_tx_data    (tx_data),
    .o_tx_start   (tx_start),
    .i_tx_done    (tx_done),
    .i_rx_data    (rx_data),
    .i_rx_done    (rx_done),
    .o_resp_word  (resp_word),
    .o_resp_valid (resp_valid),
    .o_resp_kind  (resp_kind),
    .o_resp_index (resp_index),
    .o_done       (done),
    .o_error      (error),
    .o_state      (st)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_txs = 0;
  int n_done = 0;
  int n_err = 0;
  logic [7:0]  tx_log[$];
  logic [7:0]  rx_bytes[$];
  logic [40:0] obs[$];
  logic [40:0] exp_q[$];

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (resp_valid)
      obs.push_back({resp_kind, resp_index, resp_word});
    if (done) n_done++;
    if (error) n_err++;
    if (tx_start) n_txs++;
  end

  // UART TX stand-in: done after a random delay
  initial forever begin
    logic [7:0] b;
    @(negedge clk);
    if (tx_start) begin
      b = tx_data;
      tx_log.push_back(b);
      repeat ($urandom_range(1, 4)) @(negedge clk);
      check("tx_stable", tx_data, b);
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got hang want finish");
    $fatal(1);
  end

  function automatic logic [31:0] word_at(int p);
    return {rx_bytes[p], rx_bytes[p+1],
            rx_bytes[p+2], rx_bytes[p+3]};
  endfunction

  function automatic int need(logic [7:0] c);
    case (c)
      CMD_SEND_PC:  return 4;
      CMD_SEND_MEM: return 128;
      CMD_SEND_BR:  return 128;
      CMD_STEP:     return 260;
      default:      return 0;
    endcase
  endfunction

  function automatic void build_exp(logic [7:0] c);
    int p = 0;
    exp_q.delete();
    if (c == CMD_SEND_PC || c == CMD_STEP) begin
      exp_q.push_back({2'd0, 7'd0, word_at(0)});
      p = 4;
    end
    if (c == CMD_SEND_MEM || c == CMD_STEP) begin
      for (int i = 0; i < 128; i++)
        exp_q.push_back({2'd1, 7'(i), 24'd0,
                         rx_bytes[p+i]});
      p += 128;
    end
    if (c == CMD_SEND_BR || c == CMD_STEP)
      for (int i = 0; i < 32; i++)
        exp_q.push_back({2'd2, 7'(i),
                         word_at(p + 4*i)});
  endfunction

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic compare(input string tag);
    check({tag, "_count"}, obs.size(), exp_q.size());
    for (int i = 0; i < obs.size() &&
         i < exp_q.size(); i++)
      check(tag, obs[i], exp_q[i]);
  endtask

  task automatic issue(input logic [7:0] c);
    int k = 0;
    while (!cmd_ready && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("cmd_ready_wait", cmd_ready, 1);
    cmd = c;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd = '0;
  endtask

  task automatic wait_rx();
    int k = 0;
    while (st < 4'd6 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("rx_entry", st >= 4'd6, 1);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (st != 4'd1 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("idle_wait", st, 4'd1);
    tick(2);
  endtask

  task automatic rx_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic run_rx(input logic [7:0] c,
                        input bit preset);
    int d0, e0, t0, n;
    n = need(c);
    if (!preset) begin
      rx_bytes.delete();
      for (int i = 0; i < n; i++)
        rx_bytes.push_back(8'($urandom));
    end
    rx_byte(8'($urandom));
    rx_byte(8'($urandom));
    obs.delete();
    tick(1);
    d0 = n_done; e0 = n_err; t0 = n_txs;
    issue(c);
    wait_rx();
    cmd = CMD_START;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      rx_byte(rx_bytes[i]);
      if (i == n - 1)
        check("valid_lat", resp_valid, 1);
      else
        tick($urandom_range(0, 2));
    end
    wait_idle();
    build_exp(c);
    compare("strobe");
    check("resp_hold", {resp_valid, resp_word},
          {1'b0, exp_q[exp_q.size()-1][31:0]});
    check("done_cnt", n_done - d0, 1);
    check("err_cnt", n_err - e0, 0);
    check("tx_cnt", n_txs - t0, 1);
    check("tx_cmd", tx_log[tx_log.size()-1], c);
  endtask

  task automatic run_ctrl(input logic [7:0] c);
    int d0, t0;
    obs.delete();
    d0 = n_done; t0 = n_txs;
    issue(c);
    wait_idle();
    check("ctrl_done", n_done - d0, 1);
    check("ctrl_tx", n_txs - t0, 1);
    check("ctrl_byte", tx_log[tx_log.size()-1], c);
    check("ctrl_resp", obs.size(), 0);
  endtask

  task automatic run_bad(input logic [7:0] c);
    int e0, t0;
    e0 = n_err; t0 = n_txs;
    issue(c);
    check("bad_err_pulse", error, 1);
    for (int i = 0; i < 3; i++) begin
      check("bad_ready", cmd_ready, 1);
      tick(1);
    end
    check("bad_err_cnt", n_err - e0, 1);
    check("bad_tx", n_txs - t0, 0);
    check("bad_state", st, 4'd1);
  endtask

  task automatic run_prog();
    logic [7:0] pq[$];
    int d0, t0, k;
    tx_log.delete();
    d0 = n_done; t0 = n_txs;
    issue(CMD_WRITE_IM);
    for (int i = 0; i < 256; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        prog_valid = 1'b0;
        tick($urandom_range(1, 5));
      end
      prog_data = 8'($urandom);
      pq.push_back(prog_data);
      prog_valid = 1'b1;
      #1;
      k = 0;
      while (!prog_ready && k < 200) begin
        @(negedge clk);
        #1;
        k++;
      end
      if (!prog_ready) begin
        check("prog_ready", prog_ready, 1);
        break;
      end
      @(negedge clk);
    end
    prog_valid = 1'b0;
    wait_idle();
    check("prog_tx_cnt", n_txs - t0, 257);
    check("prog_done", n_done - d0, 1);
    check("prog_log_len", tx_log.size(), 257);
    if (tx_log.size() == 257) begin
      check("prog_first", tx_log[0], 8'h01);
      for (int i = 0; i < 256; i++)
        check("prog_byte", tx_log[i+1], pq[i]);
    end
  endtask

  task automatic run_timeout();
    int d0, e0, k;
    rx_bytes.delete();
    for (int i = 0; i < 10; i++)
      rx_bytes.push_back(8'($urandom));
    obs.delete();
    d0 = n_done; e0 = n_err;
    issue(CMD_SEND_MEM);
    wait_rx();
    for (int i = 0; i < 10; i++) rx_byte(rx_bytes[i]);
    k = 0;
    while (!error && k < TMO + 20) begin
      @(negedge clk);
      k++;
    end
    check("tmo_latency",
          (k >= TMO - 2 && k <= TMO + 2), 1);
    check("tmo_state", st, 4'd1);
    tick(3);
    check("tmo_err", n_err - e0, 1);
    check("tmo_nodone", n_done - d0, 0);
    build_exp(CMD_SEND_MEM);
    while (exp_q.size() > 10) void'(exp_q.pop_back());
    compare("tmo_strobe");
  endtask

  task automatic run_reset_br();
    int d0, e0;
    rx_bytes.delete();
    for (int i = 0; i < 154; i++)
      rx_bytes.push_back(8'($urandom) | 8'h01);
    d0 = n_done; e0 = n_err;
    issue(CMD_STEP);
    wait_rx();
    for (int i = 0; i < 154; i++) rx_byte(rx_bytes[i]);
    check("pre_rst_kind", resp_kind, 2'd2);
    rst = 1'b1;
    #1;
    check("rst_state", st, 4'd1);
    check("rst_word", resp_word, 0);
    check("rst_kind_idx", {resp_kind, resp_index}, 0);
    check("rst_tx", {tx_data, tx_start}, 0);
    check("rst_strobes",
          {resp_valid, done, error, prog_ready}, 0);
    tick(2);
    rst = 1'b0;
    tick(3);
    check("rst_ready", cmd_ready, 1);
    check("rst_nodone", n_done - d0, 0);
    check("rst_noerr", n_err - e0, 0);
  endtask

  initial begin
    tick(1);
    #1;
    check("r_state", st, 4'd1);
    check("r_ready", cmd_ready, 1);
    check("r_word", resp_word, 0);
    check("r_kind_idx", {resp_kind, resp_index}, 0);
    check("r_tx", {tx_data, tx_start}, 0);
    check("r_strobes",
          {resp_valid, done, error, prog_ready}, 0);
    @(negedge clk);
    rst = 1'b0;
    tick(2);
    check("r_ready_rel", cmd_ready, 1);

    run_bad(8'h09);
    run_bad(8'h00);
    run_bad(8'($urandom_range(9, 255)));

    rx_bytes = '{8'h00, 8'h00, 8'h00, 8'h2C};
    run_rx(CMD_SEND_PC, 1'b1);
    check("pc_word", resp_word, 32'h2C);

    run_ctrl(CMD_START);
    run_ctrl(CMD_STEP_BY_STEP);
    run_ctrl(CMD_CONTINUE);
    run_rx(CMD_SEND_MEM, 1'b0);
    run_rx(CMD_SEND_BR, 1'b0);
    run_prog();
    run_rx(CMD_STEP, 1'b0);
    run_timeout();
    run_reset_br();
    run_rx(CMD_SEND_PC, 1'b0);

    for (int r = 0; r < 5; r++) begin
      case ($urandom_range(0, 4))
        0: run_rx(CMD_SEND_PC, 1'b0);
        1: run_rx(CMD_SEND_MEM, 1'b0);
        2: run_rx(CMD_SEND_BR, 1'b0);
        3: run_rx(CMD_STEP, 1'b0);
        default: run_ctrl(CMD_CONTINUE);
      endcase
    end

    $display("Result: errors=%0d of %0d checks",
             n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/debug_host.md
DEBUG_HOST -- requirements
Module: debug_host

Interface
REQ-001 Parameters SHALL be:
- NB_DATA, 8, UART byte width.
- NB_WORD, 32, assembled response word width.
- TIMEOUT_CYCLES, 100000, maximum idle clocks allowed between expected RX bytes.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- i_clock  in  1  single clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_cmd_valid  in  1  user command request.
- i_cmd  in  8  command code.
- o_cmd_ready  out  1  high only in IDLE.
- i_prog_valid  in  1  program byte available.
- i_prog_data  in  8  program byte.
- o_prog_ready  out  1  program byte accepted this cycle.
- o_tx_data  out  8  byte to UART TX.
- o_tx_start  out  1  TX start pulse.
- i_tx_done  in  1  TX finished the byte.
- i_rx_data  in  8  byte from UART RX.
- i_rx_done  in  1  RX byte valid, one cycle.
- o_resp_word  out  32  assembled response word.
- o_resp_valid  out  1  one-cycle strobe for o_resp_word.
- o_resp_kind  out  2  response type: 0 PC, 1 MEM, 2 BR.
- o_resp_index  out  7  word index within its kind.
- o_done  out  1  one-cycle strobe at command completion.
- o_error  out  1  one-cycle strobe on bad command or timeout.
- o_state  out  4  current FSM state.

Function
REQ-003 Command codes SHALL be: 1 WRITE_IM, 2 START, 3 STEP_BY_STEP, 4 SEND_BR, 5 SEND_MEM, 6 SEND_PC, 7 STEP, 8 CONTINUE.
REQ-004 FSM states SHALL be: IDLE=1, TX_CMD=2, WAIT_CMD=3, TX_PROG=4, WAIT_PROG=5, RX_PC=6, RX_MEM=7, RX_BR=8.
REQ-005 IDLE: when i_cmd_valid is high and i_cmd is in 1..8, the command SHALL be latched and the FSM SHALL go to TX_CMD. Any other code SHALL pulse o_error and remain in IDLE.
REQ-006 TX_CMD: the command byte SHALL be placed on o_tx_data, o_tx_start SHALL pulse for exactly one cycle, and the FSM SHALL go to WAIT_CMD. o_tx_data SHALL stay stable until i_tx_done.
REQ-007 On i_tx_done in WAIT_CMD, the next state SHALL depend on the command:
- WRITE_IM: TX_PROG.
- SEND_PC or STEP: RX_PC.
- SEND_MEM: RX_MEM.
- SEND_BR: RX_BR.
- START, STEP_BY_STEP, CONTINUE: pulse o_done and return to IDLE.
REQ-008 TX_PROG: when i_prog_valid is high, the FSM SHALL pulse o_prog_ready, latch the byte, pulse o_tx_start, and go to WAIT_PROG. When i_prog_valid is low it SHALL wait with no timeout.
REQ-009 WAIT_PROG: on i_tx_done an 8-bit program counter SHALL increment. When it wraps 255->0 (256 bytes sent), the FSM SHALL pulse o_done and return to IDLE. Otherwise it SHALL return to TX_PROG.
REQ-010 RX_PC: 4 bytes SHALL be assembled MSB first into one word, emitted with kind 0, index 0. Next state: STEP goes to RX_MEM; SEND_PC pulses o_done and goes to IDLE.
REQ-011 RX_MEM: 128 bytes SHALL each be emitted as a zero-extended word, kind 1, index 0..127. After index 127, STEP goes to RX_BR; SEND_MEM pulses o_done and goes to IDLE.
REQ-012 RX_BR: 128 bytes SHALL form 32 MSB-first words, kind 2, index 0..31. After word 31 the FSM SHALL pulse o_done and go to IDLE.
REQ-013 Timing of o_resp_valid: it SHALL assert the cycle after the i_rx_done carrying the word's last byte. The word, kind and index SHALL hold until the next strobe.
REQ-014 Byte and word counters SHALL clear on entry to each RX state.
REQ-015 Timeout counter:
- It SHALL count clocks in the RX_* states and in WAIT_CMD/WAIT_PROG.
- It SHALL clear on every i_rx_done or i_tx_done.
- On reaching TIMEOUT_CYCLES-1, the FSM SHALL pulse o_error, abandon the command without o_done, and return to IDLE.
REQ-016 i_rx_done arriving in IDLE, TX_* or WAIT_* states SHALL be discarded and SHALL NOT advance any counter.
REQ-017 i_cmd_valid outside IDLE SHALL be ignored. i_tx_done outside WAIT_* SHALL be ignored.
REQ-018 If i_rx_done and the timeout terminal count coincide, the received byte SHALL win and the timeout SHALL clear.

Reset
REQ-019 On i_reset high, asynchronously:
- state SHALL be IDLE.
- All counters SHALL be 0.
- o_tx_data, o_resp_word, o_resp_kind and o_resp_index SHALL be 0.
- o_tx_start, o_resp_valid, o_done, o_error and o_prog_ready SHALL be 0.
- o_cmd_ready SHALL be 1 after reset release.
REQ-020 Reset mid-command SHALL abort with no o_done or o_error pulse. The first command after release SHALL be accepted normally.

Structure
REQ-021 Command codes, state encodings and response-kind codes SHALL live in a shared debug package that is also used by the target-side debug unit.
REQ-022 The byte-to-word shift/assembly logic SHALL be a sub-module, debug_word_assembler (byte in, byte count, word out, valid out).

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- SEND_PC, RX bytes 00 00 00 2C -> one strobe with word 0x0000002C, kind 0, index 0, then o_done.
- WRITE_IM with 256 program bytes -> 257 o_tx_start pulses (first byte 0x01) and o_done after the 256th i_tx_done.
- STEP with 260 RX bytes -> 1 PC, 128 MEM and 32 BR strobes in order; last BR index 31; a single o_done.
- i_cmd=0x09 -> o_error pulse, no o_tx_start, o_cmd_ready stays 1.
- SEND_MEM with RX stopped after 10 bytes -> o_error after TIMEOUT_CYCLES, state IDLE, no o_done.
- i_reset asserted at BR word 5 -> outputs zero immediately; a following SEND_PC completes correctly.
